// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the parametrised APB memory slave.
//   - apb_state_e : access FSM states (IDLE, WAIT, READY)
//   - CNT_W       : width of the wait-state counter (covers 0..15)
//   - calc_lsb    : byte-offset bits of a word, log2(DATA_W/8)
//   - calc_idx_w  : word-index bits, log2(DEPTH)
//   - addr_err    : misaligned / out-of-range decode of a byte address
// ---------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } apb_state_e;

   localparam int CNT_W = 4;

   function automatic int calc_lsb(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int calc_idx_w(input int depth);
      return $clog2(depth);
   endfunction

   // Address is widened to 64 bits so one function serves every ADDR_W.
   function automatic logic addr_err(input logic [63:0] addr,
                                     input int          lsb,
                                     input int          depth);
      logic [63:0] mask;
      logic [63:0] word;
      mask = (64'd1 << lsb) - 64'd1;
      word = addr >> lsb;
      return ((addr & mask) != 64'd0) || (word >= 64'(depth));
   endfunction

endpackage

// File: rtl/apb_byte_ram.sv
// ---------------------------------------------------------------------------
// apb_byte_ram
// DEPTH x DATA_W storage with per-byte write enables, asynchronous read and
// asynchronous clear of every word.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low clear of all words
//   we    in  write enable for this cycle
//   idx   in  word index for both read and write
//   wdata in  write data
//   strb  in  byte-lane enables (lane i = wdata[8i+7:8i])
//   rdata out contents of word idx
// ---------------------------------------------------------------------------
module apb_byte_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [IDX_W-1:0]    idx,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] strb,
   output logic [DATA_W-1:0]   rdata
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < DEPTH; w++) begin
            mem_q[w] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (strb[b]) begin
               mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
// Parametrised APB memory slave with wait states, byte strobes and
// address-decode error response.
// Ports:
//   P_clk    in  rising-edge clock
//   P_rst    in  asynchronous active-low reset
//   P_addr   in  byte address
//   P_selx   in  slave select
//   P_enable in  access-phase indicator
//   P_write  in  1 = write, 0 = read
//   P_wdata  in  write data
//   P_strb   in  byte-lane write strobes
//   P_ready  out transfer completes this cycle
//   P_slverr out error response (only while P_ready)
//   P_rdata  out read data (only while P_ready on an error-free read)
// ---------------------------------------------------------------------------
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                P_clk,
   input  logic                P_rst,
   input  logic [ADDR_W-1:0]   P_addr,
   input  logic                P_selx,
   input  logic                P_enable,
   input  logic                P_write,
   input  logic [DATA_W-1:0]   P_wdata,
   input  logic [DATA_W/8-1:0] P_strb,
   output logic                P_ready,
   output logic                P_slverr,
   output logic [DATA_W-1:0]   P_rdata
);

   localparam int LSB   = calc_lsb(DATA_W);
   localparam int IDX_W = calc_idx_w(DEPTH);
   localparam int NB    = DATA_W / 8;

   // First value of the wait counter; unused when there are no wait states.
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

   apb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NB-1:0]     strb_q,  strb_d;

   logic              err;
   logic [IDX_W-1:0]  idx;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   assign err = addr_err(64'(addr_q), LSB, DEPTH);
   assign idx = addr_q[LSB+IDX_W-1:LSB];

   // Only the setup cycle seen in IDLE updates the latches, so anything the
   // master changes during the access phase has no effect.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      case (state_q)
         IDLE: begin
            if (P_selx && !P_enable) begin
               addr_d  = P_addr;
               write_d = P_write;
               wdata_d = P_wdata;
               strb_d  = P_strb;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_STATES == 0) ? READY : WAIT;
            end
         end
         WAIT: begin
            if (!(P_selx && P_enable)) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         READY: begin
            // Both completion and abort leave READY after one cycle.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge P_clk or negedge P_rst) begin
      if (!P_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
      end
   end

   // An abort in READY (select or enable low) must not commit the write.
   assign ram_we = (state_q == READY) && P_selx && P_enable && write_q && !err;

   apb_byte_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_ram (
      .clk   (P_clk),
      .rst_n (P_rst),
      .we    (ram_we),
      .idx   (idx),
      .wdata (wdata_q),
      .strb  (strb_q),
      .rdata (ram_rdata)
   );

   // Outputs are pure decodes of registered state and memory contents.
   assign P_ready  = (state_q == READY);
   assign P_slverr = P_ready && err;
   assign P_rdata  = (P_ready && !write_q && !err) ? ram_rdata : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 2 and 3 wait states) on a
// shared bus with individual selects, checked every cycle against a
// transaction-level model of the memory and response timing.
module tb_apb_mem_slave;

   logic        P_clk = 1'b0;
   logic        P_rst = 1'b0;
   logic [31:0] P_addr = '0;
   logic [2:0]  selx = '0;
   logic        P_enable = 1'b0;
   logic        P_write = 1'b0;
   logic [31:0] P_wdata = '0;
   logic [3:0]  P_strb = '0;

   logic        readyW  [3];
   logic        slverrW [3];
   logic [31:0] rdataW  [3];

   int          wsOf [3] = '{0, 2, 3};

   logic        expReady [3];
   logic        expErr   [3];
   logic [31:0] expRdata [3];
   logic [31:0] modelMem [3][16];

   int          total = 0;
   int          bad = 0;
   bit          checkOn = 1'b0;

   int          readyCnt;
   int          readyAt;
   logic        obsErr;
   logic [31:0] obsRdata;

   always #5 P_clk = ~P_clk;

   apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
      .P_clk(P_clk), .P_rst(P_rst), .P_addr(P_addr), .P_selx(selx[0]),
      .P_enable(P_enable), .P_write(P_write), .P_wdata(P_wdata), .P_strb(P_strb),
      .P_ready(readyW[0]), .P_slverr(slverrW[0]), .P_rdata(rdataW[0]));

   apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(2)) dut1 (
      .P_clk(P_clk), .P_rst(P_rst), .P_addr(P_addr), .P_selx(selx[1]),
      .P_enable(P_enable), .P_write(P_write), .P_wdata(P_wdata), .P_strb(P_strb),
      .P_ready(readyW[1]), .P_slverr(slverrW[1]), .P_rdata(rdataW[1]));

   apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(3)) dut2 (
      .P_clk(P_clk), .P_rst(P_rst), .P_addr(P_addr), .P_selx(selx[2]),
      .P_enable(P_enable), .P_write(P_write), .P_wdata(P_wdata), .P_strb(P_strb),
      .P_ready(readyW[2]), .P_slverr(slverrW[2]), .P_rdata(rdataW[2]));

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic clearExp();
      for (int k = 0; k < 3; k++) begin
         expReady[k] = 1'b0;
         expErr[k]   = 1'b0;
         expRdata[k] = '0;
      end
   endtask

   task automatic clearModel();
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 16; w++) begin
            modelMem[k][w] = '0;
         end
      end
   endtask

   // Every cycle the bus is observed away from the active edge.
   always @(negedge P_clk) begin
      if (checkOn) begin
         for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("dut%0d P_ready", d), 64'(readyW[d]), 64'(expReady[d]));
            checkOutput($sformatf("dut%0d P_slverr", d), 64'(slverrW[d]), 64'(expErr[d]));
            checkOutput($sformatf("dut%0d P_rdata", d), 64'(rdataW[d]), 64'(expRdata[d]));
         end
      end
   end

   // One APB transfer to instance d. abortAt drops select in that cycle;
   // rstAt asserts reset in the middle of that cycle (-1 disables either).
   task automatic applyStimulus(input int d, input logic [31:0] addr, input logic wr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input int abortAt, input int rstAt);
      logic errExp;
      int   idx;
      int   ws;
      ws       = wsOf[d];
      errExp   = (addr % 4 != 0) || (addr / 4 >= 16);
      idx      = int'((addr / 4) % 16);
      readyCnt = 0;
      readyAt  = -1;
      obsErr   = 1'b0;
      obsRdata = '0;
      for (int c = 0; c <= ws + 1; c++) begin
         @(posedge P_clk);
         #1;
         clearExp();
         if (c == 0) begin
            selx     = '0;
            selx[d]  = 1'b1;
            P_enable = 1'b0;
            P_addr   = addr;
            P_write  = wr;
            P_wdata  = wdata;
            P_strb   = strb;
         end else begin
            P_enable = 1'b1;
            P_addr   = $urandom;
            P_wdata  = $urandom;
            P_strb   = 4'($urandom);
         end
         if (c == abortAt) begin
            selx     = '0;
            P_enable = 1'b0;
         end else if (c == ws + 1) begin
            expReady[d] = 1'b1;
            expErr[d]   = errExp;
            expRdata[d] = (!wr && !errExp) ? modelMem[d][idx] : 32'h0;
         end
         if (c == rstAt) begin
            #2;
            P_rst = 1'b0;
            clearExp();
            clearModel();
            #1;
            for (int k = 0; k < 3; k++) begin
               checkOutput($sformatf("async reset dut%0d P_ready", k), 64'(readyW[k]), 64'd0);
               checkOutput($sformatf("async reset dut%0d P_slverr", k), 64'(slverrW[k]), 64'd0);
               checkOutput($sformatf("async reset dut%0d P_rdata", k), 64'(rdataW[k]), 64'd0);
            end
         end
         @(negedge P_clk);
         if (readyW[d]) begin
            readyCnt++;
            readyAt  = c;
            obsErr   = slverrW[d];
            obsRdata = rdataW[d];
         end
         if (c == abortAt || c == rstAt) return;
         if (c == ws + 1 && wr && !errExp) begin
            for (int b = 0; b < 4; b++) begin
               if (strb[b]) modelMem[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
         end
      end
   endtask

   // Idle cycle; a stray cycle raises select and enable with no setup.
   task automatic idleCycle(input bit stray);
      @(posedge P_clk);
      #1;
      clearExp();
      selx     = '0;
      P_enable = 1'($urandom);
      if (stray) begin
         selx[$urandom_range(0, 2)] = 1'b1;
         P_enable = 1'b1;
      end
      @(negedge P_clk);
   endtask

   task automatic releaseReset();
      @(posedge P_clk);
      #1;
      clearExp();
      selx     = '0;
      P_enable = 1'b0;
      P_rst    = 1'b1;
      @(negedge P_clk);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          d;
      int          abortAt;
      logic [31:0] a;
      clearExp();
      clearModel();
      checkOn = 1'b1;
      #3;
      checkOutput("reset dut0 P_ready", 64'(readyW[0]), 64'd0);
      checkOutput("reset dut2 P_rdata", 64'(rdataW[2]), 64'd0);
      repeat (2) @(negedge P_clk);
      releaseReset();

      // Full-word write then read, no wait states.
      applyStimulus(0, 32'h08, 1'b1, 32'hDEADBEEF, 4'hF, -1, -1);
      checkOutput("wr 0x08 ready cycle", 64'(readyAt), 64'd1);
      checkOutput("wr 0x08 slverr", 64'(obsErr), 64'd0);
      applyStimulus(0, 32'h08, 1'b0, 32'h0, 4'h0, -1, -1);
      checkOutput("rd 0x08 ready cycle", 64'(readyAt), 64'd1);
      checkOutput("rd 0x08 rdata", 64'(obsRdata), 64'hDEADBEEF);

      // Byte-lane strobes.
      applyStimulus(0, 32'h04, 1'b1, 32'h11223344, 4'hF, -1, -1);
      applyStimulus(0, 32'h04, 1'b1, 32'hAABBCCDD, 4'b0101, -1, -1);
      applyStimulus(0, 32'h04, 1'b0, 32'h0, 4'h0, -1, -1);
      checkOutput("strobe merge rdata", 64'(obsRdata), 64'h11BB33DD);

      // Three wait states.
      applyStimulus(2, 32'h0C, 1'b1, 32'h600DF00D, 4'hF, -1, -1);
      idleCycle(1'b0);
      applyStimulus(2, 32'h0C, 1'b0, 32'h0, 4'h0, -1, -1);
      checkOutput("ws3 ready cycle", 64'(readyAt), 64'd4);
      checkOutput("ws3 ready count", 64'(readyCnt), 64'd1);
      checkOutput("ws3 rdata", 64'(obsRdata), 64'h600DF00D);

      // Decode errors: out of range write aliases word 0 but must not touch it.
      applyStimulus(0, 32'h00, 1'b1, 32'hCAFEF00D, 4'hF, -1, -1);
      applyStimulus(0, 32'h40, 1'b1, 32'h99999999, 4'hF, -1, -1);
      checkOutput("oob write slverr", 64'(obsErr), 64'd1);
      applyStimulus(0, 32'h00, 1'b0, 32'h0, 4'h0, -1, -1);
      checkOutput("word0 after oob write", 64'(obsRdata), 64'hCAFEF00D);
      applyStimulus(0, 32'h02, 1'b0, 32'h0, 4'h0, -1, -1);
      checkOutput("misaligned read slverr", 64'(obsErr), 64'd1);
      checkOutput("misaligned read rdata", 64'(obsRdata), 64'd0);

      // Abort in the second wait cycle.
      applyStimulus(1, 32'h10, 1'b1, 32'h12345678, 4'hF, -1, -1);
      applyStimulus(1, 32'h10, 1'b1, 32'h00000055, 4'hF, 2, -1);
      checkOutput("abort ready count", 64'(readyCnt), 64'd0);
      applyStimulus(1, 32'h10, 1'b0, 32'h0, 4'h0, -1, -1);
      checkOutput("after abort rdata", 64'(obsRdata), 64'h12345678);

      // Reset while P_ready is high, then reset mid-WAIT.
      applyStimulus(0, 32'h08, 1'b0, 32'h0, 4'h0, -1, 1);
      releaseReset();
      applyStimulus(2, 32'h08, 1'b1, 32'h0BADCAFE, 4'hF, -1, -1);
      applyStimulus(2, 32'h08, 1'b1, 32'h77777777, 4'hF, -1, 2);
      releaseReset();
      applyStimulus(2, 32'h08, 1'b0, 32'h0, 4'h0, -1, -1);
      checkOutput("dut2 0x08 after reset", 64'(obsRdata), 64'd0);
      applyStimulus(0, 32'h08, 1'b0, 32'h0, 4'h0, -1, -1);
      checkOutput("dut0 0x08 after reset", 64'(obsRdata), 64'd0);

      // Randomised traffic, including errors, aborts and stray enables.
      for (int n = 0; n < 300; n++) begin
         d = int'($urandom_range(0, 2));
         a = 32'($urandom_range(0, 79));
         abortAt = -1;
         if (wsOf[d] > 0 && $urandom_range(0, 5) == 0) begin
            abortAt = int'($urandom_range(1, wsOf[d]));
         end
         applyStimulus(d, a, 1'($urandom), $urandom, 4'($urandom), abortAt, -1);
         if ($urandom_range(0, 3) == 0) idleCycle(1'($urandom));
      end
      idleCycle(1'b0);
      idleCycle(1'b0);
      checkOn = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB memory slave: the next generation of the team's fixed 32x32 APB slave. Adds configurable data width, depth and wait states, byte-lane write strobes, and address-decode error reporting on P_slverr. The address, control and write data are latched during the setup phase. It sits on the peripheral bus behind the APB bridge as a scratchpad or register bank.

Parameters:
ADDR_W, 32, width of P_addr (byte address)
DATA_W, 32, data width; must be 8, 16, 32 or 64
DEPTH, 32, number of DATA_W words; power of two, at least 2
WAIT_STATES, 0, extra access-phase cycles before P_ready (0..15)

Ports:
P_clk  in  1  clock, rising-edge
P_rst  in  1  reset, asynchronous, active-low (0 = reset)
P_addr  in  ADDR_W  byte address
P_selx  in  1  slave select
P_enable  in  1  access-phase indicator
P_write  in  1  1 = write, 0 = read
P_wdata  in  DATA_W  write data
P_strb  in  DATA_W/8  byte-lane write strobes
P_ready  out  1  transfer completes this cycle
P_slverr  out  1  error response; valid only while P_ready=1
P_rdata  out  DATA_W  read data; valid only while P_ready=1 and P_write=0

Behaviour:
- Reset (P_rst=0, asynchronous):
  - FSM goes to IDLE and the wait counter clears.
  - Latched address, write flag and strobes clear.
  - All memory words clear to 0.
  - Outputs: P_ready=0, P_slverr=0, P_rdata=0.
- Constants: LSB = log2(DATA_W/8). Word index = latched_addr[LSB+log2(DEPTH)-1 : LSB].
- Error condition (err), decoded from the latched address:
  - misaligned: latched_addr[LSB-1:0] != 0; or
  - out of range: latched_addr >> LSB >= DEPTH.
- FSM states: IDLE, WAIT, READY. All transitions occur on the rising edge of P_clk.
- IDLE:
  - On P_selx=1 and P_enable=0 (setup phase), latch P_addr, P_write, P_wdata and P_strb.
  - Then go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0; otherwise go to READY.
  - P_enable=1 without a preceding setup is ignored; FSM stays in IDLE.
- WAIT:
  - P_ready=0. Counter decrements each cycle; at counter=0 go to READY.
- READY:
  - P_ready=1 (decoded from state, no combinational path from inputs).
  - P_slverr = err.
  - P_rdata = mem[index] on a read with err=0; otherwise 0.
  - Completion edge with P_selx=1 and P_enable=1:
    - write with err=0: byte lane i of mem[index] takes latched wdata lane i where strb[i]=1;
    - write with err=1: memory is not modified;
    - next state is IDLE.
- Latency: a transfer completes 2+WAIT_STATES cycles after the setup cycle begins.
- Back-to-back transfers: the master's next setup cycle follows completion; IDLE samples it, so there is no dead cycle beyond the APB minimum.
- Abort: P_selx=0 or P_enable=0 while in WAIT or READY sends the FSM to IDLE next edge. No write occurs, and P_ready drops in the same cycle the FSM leaves READY.
- Inputs that change during the access phase are ignored; only the values latched at setup are used.
- Outside READY: P_ready=0, P_slverr=0, P_rdata=0.
- Reset asserted mid-transfer: immediate return to IDLE; any pending write is dropped.

Decomposition:
- Shared package apb_pkg:
  - FSM state enum (IDLE, WAIT, READY);
  - localparams for LSB and index width derived from DATA_W and DEPTH;
  - a function that computes err from the address.
- Sub-module apb_byte_ram: DEPTH x DATA_W array with per-byte write enable, asynchronous read and asynchronous clear.
- FSM, wait counter and address latches stay in apb_mem_slave.

Test Plan:
- DATA_W=32, DEPTH=16, WAIT_STATES=0: write 0xDEADBEEF to 0x08 (strb=4'hF), then read 0x08 -> both transfers have P_ready on the 2nd cycle, P_slverr=0, P_rdata=0xDEADBEEF.
- Byte strobes: word 0x04 holds 0x11223344; write 0xAABBCCDD with strb=4'b0101 -> a read returns 0x11BB33DD.
- WAIT_STATES=3: read 0x0C -> P_ready=0 for exactly 4 cycles after setup, asserts on cycle 5 for one cycle.
- Errors:
  - write to 0x40 (index 16 >= DEPTH) -> P_slverr=1 with P_ready, memory unchanged;
  - read of 0x02 (misaligned) -> P_slverr=1, P_rdata=0.
- Abort: WAIT_STATES=2, write 0x55 to 0x10 and drop P_selx in the 2nd wait cycle -> FSM returns to IDLE, P_ready is never asserted, and a later read of 0x10 returns the old value.
- Reset: assert P_rst=0 mid-WAIT -> outputs go to 0 asynchronously; after release, a read of 0x08 returns 0.
